// File: rtl/sb_req_queue.sv
// sb_req_queue: request queue and issue controller in front of the simple-bus
// processor interface. Client commands are buffered in a small FIFO and replayed
// one at a time as an access pulse plus held control/address/data. Read data
// from the bus comes back to the client as a single-cycle response.
//
// Optional feature: define SB_STATS_EN to add saturating 16-bit issue counters
// (stat_rd, stat_wr). Without the macro these ports and counters do not exist.
module sb_req_queue #(
    parameter int DEPTH      = 4,   // FIFO entries, power of two, >= 2
    parameter int GAP_CYCLES = 2    // idle cycles after each transaction, 0..15
) (
    input  logic        clock,
    input  logic        resetN,
    // client command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    // processor interface side
    output logic        pb_access,
    output logic        pb_doRead,
    output logic        pb_wDataRdy,
    output logic [23:0] pb_addr,
    output logic [7:0]  pb_wdata,
    input  logic        pb_idle,
    input  logic        pb_rd_valid,
    input  logic [7:0]  pb_rd_data,
    // client response port
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy
`ifdef SB_STATS_EN
    ,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr
`endif
);

    localparam int            AW         = $clog2(DEPTH);
    localparam int            EW         = 33;             // {read, addr[23:0], wdata[7:0]}
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [3:0]    GAP_LOAD   = GAP_CYCLES[3:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);

    // A full queue refuses the push even when a pop happens on the same edge.
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    // Storage array: written on push, no reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_read, cmd_addr, cmd_wdata};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic [3:0] gap_cnt_reg;
    logic [3:0] gap_cnt_next;
    logic       clear_hold;
    logic       rsp_capture;

    logic        pb_access_reg;
    logic        pb_doRead_reg;
    logic        pb_wDataRdy_reg;
    logic [23:0] pb_addr_reg;
    logic [7:0]  pb_wdata_reg;
    logic        rsp_valid_reg;
    logic [7:0]  rsp_data_reg;

    // State and gap counter registers.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Next-state logic plus the pop / hold-clear / read-capture strobes.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        pop          = 1'b0;
        clear_hold   = 1'b0;
        rsp_capture  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // The FIFO head only becomes visible one edge after its push.
                if (!fifo_empty && pb_idle) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!pb_idle) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Bus data is only meaningful while a read is outstanding.
                rsp_capture = pb_rd_valid && pb_doRead_reg;
                if (pb_idle) begin
                    clear_hold = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_GAP;
                        gap_cnt_next = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                // Stays exactly GAP_CYCLES cycles in this state.
                if (gap_cnt_reg <= 4'd1) begin
                    gap_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Hold registers: loaded straight from the FIFO head on pop (registered
    // RAM read), kept through the transaction, cleared when it completes.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            pb_access_reg   <= 1'b0;
            pb_doRead_reg   <= 1'b0;
            pb_wDataRdy_reg <= 1'b0;
            pb_addr_reg     <= '0;
            pb_wdata_reg    <= '0;
        end else begin
            pb_access_reg <= pop;
            if (pop) begin
                pb_doRead_reg   <= fifo_mem[rd_ptr_reg][32];
                pb_wDataRdy_reg <= !fifo_mem[rd_ptr_reg][32];
                pb_addr_reg     <= fifo_mem[rd_ptr_reg][31:8];
                pb_wdata_reg    <= fifo_mem[rd_ptr_reg][7:0];
            end else if (clear_hold) begin
                pb_doRead_reg   <= 1'b0;
                pb_wDataRdy_reg <= 1'b0;
                pb_addr_reg     <= '0;
                pb_wdata_reg    <= '0;
            end
        end
    end

    // Read response: one-cycle pulse, data held until the next capture.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= rsp_capture;
            if (rsp_capture) begin
                rsp_data_reg <= pb_rd_data;
            end
        end
    end

    assign pb_access   = pb_access_reg;
    assign pb_doRead   = pb_doRead_reg;
    assign pb_wDataRdy = pb_wDataRdy_reg;
    assign pb_addr     = pb_addr_reg;
    assign pb_wdata    = pb_wdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign busy        = (state_reg != ST_IDLE) || !fifo_empty;

`ifdef SB_STATS_EN
    // ------------------------------------------------------------------
    // Issue statistics: index 0 counts reads, index 1 counts writes.
    // ------------------------------------------------------------------
    logic [1:0] stat_hit;

    assign stat_hit[0] = (state_reg == ST_ISSUE) &&  pb_doRead_reg;
    assign stat_hit[1] = (state_reg == ST_ISSUE) && !pb_doRead_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cnt_reg;

        // Saturating counter bumped once per issued transaction of its type.
        always_ff @(posedge clock) begin
            if (!resetN) begin
                cnt_reg <= '0;
            end else if (stat_hit[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign stat_rd = g_stat[0].cnt_reg;
    assign stat_wr = g_stat[1].cnt_reg;
`endif

endmodule
